// File: rtl/alu_pkg.sv
// Shared ALUFun field encodings for the add/compare slice.
package alu_pkg;

  // ALUFun[5:4] operation groups
  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] CMP   = 2'b11;

  // ALUFun[3:1] compare codes
  localparam logic [2:0] EQ  = 3'b001;
  localparam logic [2:0] NEQ = 3'b000;
  localparam logic [2:0] LT  = 3'b010;
  localparam logic [2:0] LEZ = 3'b110;
  localparam logic [2:0] LTZ = 3'b101;
  localparam logic [2:0] GTZ = 3'b111;

  // ALUFun bit that selects subtract
  localparam int unsigned SUB_BIT = 0;

  // Compare-with-zero ops have ALUFun[3] set and ignore B.
  function automatic logic is_cmp_zero(input logic [5:0] fun);
    return (fun[5:4] == CMP) && fun[3];
  endfunction

endpackage

// File: rtl/alu_cmp_logic.sv
// Maps ALUFun and the Z/N flags onto the 1-bit compare result.
module alu_cmp_logic
  import alu_pkg::*;
(
  input  logic [5:0] ALUFun,
  input  logic       z_i,
  input  logic       n_i,
  output logic       cmp_o
);

  // Decode the compare op; anything outside the compare group reads as false.
  always_comb begin
    cmp_o = 1'b0;
    if (ALUFun[5:4] == CMP) begin
      case (ALUFun[3:1])
        EQ:      cmp_o = z_i;
        NEQ:     cmp_o = ~z_i;
        LT:      cmp_o = n_i;
        LEZ:     cmp_o = n_i | z_i;
        LTZ:     cmp_o = n_i;
        GTZ:     cmp_o = ~n_i & ~z_i;
        default: cmp_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_addcmp_unit.sv
// Registered add/subtract with Z/V/N flags and compare result for the MIPS ALU.
module alu_addcmp_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic [WIDTH-1:0] S_adder,
  output logic [WIDTH-1:0] S_cmp,
  output logic             Z,
  output logic             V,
  output logic             N
);

  localparam int unsigned Msb = WIDTH - 1;

  logic             sub;
  logic [WIDTH-1:0] bz;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic             z_d, v_d, n_d, cmp_d;
  logic [WIDTH-1:0] s_adder_q, s_cmp_q;
  logic             z_q, v_q, n_q;

  // Adder datapath and flag generation.
  always_comb begin
    sub   = ALUFun[SUB_BIT];
    bz    = is_cmp_zero(ALUFun) ? '0 : B;
    b_op  = sub ? ~bz : bz;
    sum   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    r     = sum[Msb:0];
    carry = sum[WIDTH];
    z_d   = (r == '0);
    if (Sign) begin
      // Signed overflow: effective operands share a sign that the result lost.
      v_d = (A[Msb] == b_op[Msb]) && (r[Msb] != A[Msb]);
      n_d = r[Msb] ^ v_d;
    end else begin
      // Unsigned: carry for add, borrow (no carry) for sub.
      v_d = sub ? ~carry : carry;
      n_d = sub & ~carry;
    end
  end

  alu_cmp_logic u_cmp (
    .ALUFun (ALUFun),
    .z_i    (z_d),
    .n_i    (n_d),
    .cmp_o  (cmp_d)
  );

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_adder_q <= '0;
      s_cmp_q   <= '0;
      z_q       <= 1'b0;
      v_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      s_adder_q <= r;
      s_cmp_q   <= {{(WIDTH-1){1'b0}}, cmp_d};
      z_q       <= z_d;
      v_q       <= v_d;
      n_q       <= n_d;
    end
  end

  assign S_adder = s_adder_q;
  assign S_cmp   = s_cmp_q;
  assign Z       = z_q;
  assign V       = v_q;
  assign N       = n_q;

endmodule

// File: tb/tb_alu_addcmp_unit.sv
// Self-checking bench: directed vector table, randomized ops vs. arithmetic model, reset sequence.
module tb_alu_addcmp_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic [31:0] S_adder, S_cmp;
  logic        Z, V, N;

  int tests_run;
  int tests_failed;

  alu_addcmp_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .ALUFun  (ALUFun),
    .Sign    (Sign),
    .S_adder (S_adder),
    .S_cmp   (S_cmp),
    .Z       (Z),
    .V       (V),
    .N       (N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] s_add;
    logic [31:0] s_cmp;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  typedef struct {
    logic [31:0] s_add;
    logic [31:0] s_cmp;
    logic        z;
    logic        v;
    logic        n;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " S_adder"}, S_adder, e.s_add);
    check({tag, " S_cmp"}, S_cmp, e.s_cmp);
    check({tag, " Z"}, {31'b0, Z}, {31'b0, e.z});
    check({tag, " V"}, {31'b0, V}, {31'b0, e.v});
    check({tag, " N"}, {31'b0, N}, {31'b0, e.n});
  endtask

  // Reference: exact integer arithmetic, then flags read off the true result.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] fun, input logic sign);
    exp_t        e;
    logic [31:0] bz;
    longint      x, y, t;
    logic        cmp;
    bz = (fun[5:4] == 2'b11 && fun[3]) ? 32'h0 : b;
    if (sign) begin
      x = longint'($signed(a));
      y = longint'($signed(bz));
    end else begin
      x = longint'({32'h0, a});
      y = longint'({32'h0, bz});
    end
    t = fun[0] ? x - y : x + y;
    e.s_add = t[31:0];
    e.z = (e.s_add == 32'h0);
    if (sign) begin
      e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      e.n = (t < 0);
    end else begin
      e.v = fun[0] ? (t < 0) : (t > 64'sd4294967295);
      e.n = fun[0] && (t < 0);
    end
    cmp = 1'b0;
    if (fun[5:4] == 2'b11) begin
      case (fun[3:1])
        3'b001: cmp = e.z;
        3'b000: cmp = !e.z;
        3'b010: cmp = e.n;
        3'b110: cmp = e.n || e.z;
        3'b101: cmp = e.n;
        3'b111: cmp = !e.n && !e.z;
        default: cmp = 1'b0;
      endcase
    end
    e.s_cmp = {31'b0, cmp};
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] fun, input logic sign);
    A = a; B = b; ALUFun = fun; Sign = sign;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];
  exp_t e;
  exp_t zero_e;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    zero_e = '{s_add: 32'h0, s_cmp: 32'h0, z: 1'b0, v: 1'b0, n: 1'b0};

    //            a             b             fun        sign s_add         cmp  z  v  n
    vecs[0]  = '{32'h80000001, 32'h80000001, 6'b110011, 1'b1, 32'h00000000, 32'h1, 1, 0, 0};
    vecs[1]  = '{32'h80000001, 32'h80000001, 6'b110001, 1'b1, 32'h00000000, 32'h0, 1, 0, 0};
    vecs[2]  = '{32'h00000001, 32'h00000002, 6'b110101, 1'b1, 32'hFFFFFFFF, 32'h1, 0, 0, 1};
    vecs[3]  = '{32'h00000001, 32'hFFFFFFFF, 6'b110101, 1'b0, 32'h00000002, 32'h1, 0, 1, 1};
    vecs[4]  = '{32'h80000001, 32'h00000002, 6'b111101, 1'b1, 32'h80000001, 32'h1, 0, 0, 1};
    vecs[5]  = '{32'h00000000, 32'h00000002, 6'b111101, 1'b1, 32'h00000000, 32'h1, 1, 0, 0};
    vecs[6]  = '{32'h00000005, 32'h00000002, 6'b111111, 1'b1, 32'h00000005, 32'h1, 0, 0, 0};
    vecs[7]  = '{32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b1, 32'h80000000, 32'h0, 0, 1, 0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b0, 32'h80000000, 32'h0, 0, 0, 0};
    vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000000, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 1, 0};
    vecs[10] = '{32'hFFFFFFFF, 32'h00000009, 6'b111011, 1'b1, 32'hFFFFFFFF, 32'h1, 0, 0, 1};
    vecs[11] = '{32'h00000003, 32'h00000003, 6'b110111, 1'b1, 32'h00000000, 32'h0, 1, 0, 0};
    vecs[12] = '{32'h00000007, 32'h00000003, 6'b111001, 1'b1, 32'h00000007, 32'h0, 0, 0, 0};
    vecs[13] = '{32'h00000004, 32'h00000004, 6'b010011, 1'b1, 32'h00000000, 32'h0, 1, 0, 0};

    A = 32'h0; B = 32'h0; ALUFun = 6'h0; Sign = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", zero_e);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sign);
      e = '{s_add: vecs[i].s_add, s_cmp: vecs[i].s_cmp, z: vecs[i].z, v: vecs[i].v,
            n: vecs[i].n};
      check_all($sformatf("vec%0d", i), e);
    end

    // Randomized ops against the model
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ra, rb;
      logic [5:0]  rf;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h7FFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      rf = 6'($urandom);
      if ($urandom_range(0, 1) == 1) rf[5:4] = 2'b11;
      if (rf[5:4] == 2'b11) rf[0] = 1'b1;
      rs = 1'($urandom);
      drive(ra, rb, rf, rs);
      check_all($sformatf("rand%0d", k), model(ra, rb, rf, rs));
    end

    // Asynchronous reset mid-operation
    drive(32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b1);
    check_all("pre-reset", model(32'h7FFFFFFF, 32'h00000001, 6'b000000, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    check_all("async reset", zero_e);
    @(posedge clk);
    #1;
    check_all("held reset", zero_e);
    #2 rst_n = 1'b1;
    A = 32'h00000001; B = 32'h00000002; ALUFun = 6'b110101; Sign = 1'b1;
    @(posedge clk);
    #1;
    check_all("post-release", model(32'h00000001, 32'h00000002, 6'b110101, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_addcmp_unit.md
Name: alu_addcmp_unit

Overview:
- Registered add/subtract and compare slice of the MIPS ALU.
- Computes A±B, raises Z/V/N flags, and evaluates six compare ops selected by ALUFun.
- Outputs are registered, one cycle after the inputs are sampled.
- Feeds the ALU output mux: S_adder for arithmetic ops, S_cmp for set/branch compare ops.

Parameters:
- WIDTH, 32, operand and result width. All behaviour below assumes 32; the sign bit is WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- A  in  32  operand A.
- B  in  32  operand B.
- ALUFun  in  6  operation select. [5:4]=11 selects compare; [0]=1 selects subtract; [3:1] selects the compare op.
- Sign  in  1  1 = signed (two's complement) semantics; 0 = unsigned.
- S_adder  out  32  registered sum or difference.
- S_cmp  out  32  registered compare result: 32'h1 true, 32'h0 false.
- Z  out  1  registered zero flag.
- V  out  1  registered overflow flag.
- N  out  1  registered "less-than / negative" flag.

Behaviour:
- Reset: while rst_n=0, all outputs are 0. Reset asserts asynchronously and releases on the next rising clk.
- Latency: inputs are sampled on a rising clk; outputs are valid after that edge. There is no handshake and a new op is accepted every cycle.
- Effective B (Bz):
  - Bz = 0 when ALUFun[5:4]=11 and ALUFun[3]=1 (compare-with-zero ops).
  - Otherwise Bz = B.
- Adder:
  - ALUFun[0]=0: R = A + Bz.
  - ALUFun[0]=1: R = A + ~Bz + 1.
  - R is truncated to 32 bits and drives S_adder for every ALUFun value.
- Z = (R == 0).
- V, signed (Sign=1): two's-complement overflow.
  - Add: operands share a sign and R's sign differs.
  - Sub: A and Bz differ in sign and R's sign differs from A's.
- V, unsigned (Sign=0): carry-out for add; borrow (no carry-out) for sub.
- N, signed: R[31] XOR V, i.e. true A<Bz for sub.
- N, unsigned: borrow for sub; 0 for add.
- Compare, when ALUFun[5:4]=11, decoded on ALUFun[3:1]:
  - 001 EQ: Z.
  - 000 NEQ: ~Z.
  - 010 LT: N.
  - 110 LEZ: N | Z.
  - 101 LTZ: N.
  - 111 GTZ: ~N & ~Z.
- S_cmp = {31'b0, result}.
- Compare ops require ALUFun[0]=1. If ALUFun[0]=0 with [5:4]=11, the flags still come from the addition and S_cmp is the decode above; callers never issue this.
- Any other [3:1] code (011, 100), or ALUFun[5:4]≠11: S_cmp = 0.
- Flags Z/V/N are registered for every op, including non-compare ops.

Decomposition:
- Shared package alu_pkg:
  - ALUFun group constants: ADD=2'b00, LOGIC=2'b01, SHIFT=2'b10, CMP=2'b11.
  - Compare codes: EQ=3'b001, NEQ=3'b000, LT=3'b010, LEZ=3'b110, LTZ=3'b101, GTZ=3'b111.
  - Constant SUB_BIT=0.
- One sub-module, alu_cmp_logic: purely combinational, mapping (ALUFun, Z, N) to the 1-bit compare result.
- The adder/flag datapath and the output register live in the top level.

Test Plan:
- EQ: Sign=1, ALUFun=110011, A=B=32'h80000001; one clk later → S_cmp=1, Z=1, S_adder=0, V=0.
- NEQ: ALUFun=110001, same operands → S_cmp=0, Z=1.
- LT: ALUFun=110101, Sign=1, A=1, B=2 → S_adder=32'hFFFFFFFF, N=1, S_cmp=1.
  - Repeat with Sign=0, A=1, B=32'hFFFFFFFF → S_cmp=1.
- LEZ: ALUFun=111101, Sign=1, A=32'h80000001, B=2 (B ignored) → S_adder=32'h80000001, N=1, S_cmp=1.
  - Repeat with A=0 → S_cmp=1.
  - Repeat with GTZ (111111) and A=5 → S_cmp=1.
- ADD overflow: ALUFun=000000, A=32'h7FFFFFFF, B=1.
  - Sign=1 → S_adder=32'h80000000, V=1, N=0.
  - Sign=0 → V=0.
  - A=B=32'hFFFFFFFF, Sign=0 → V=1, S_adder=32'hFFFFFFFE.
- Reset mid-operation: with outputs nonzero, drop rst_n between clock edges → all outputs 0 immediately, without waiting for a clk edge. Release → first valid result one clk after release.
